// File: rtl/dmem_io_arbiter_if.sv
// Bus bundle between the two requesters (CPU load/store, UART loader),
// the arbiter, and the data-memory / IO side.
interface dmem_io_arbiter_if;
  // CPU requester
  logic        c_req;
  logic [3:0]  c_wen;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_ack;
  // UART loader requester
  logic        u_req;
  logic [3:0]  u_wen;
  logic [31:0] u_addr;
  logic [31:0] u_wdata;
  logic [31:0] u_rdata;
  logic        u_ack;
  // memory / IO side
  logic        mRead;
  logic [3:0]  mWrite;
  logic        ioRead;
  logic        ioWrite;
  logic [31:0] addr_out;
  logic [31:0] wdata_out;
  logic [31:0] m_rdata;
  logic [23:0] io_rdata;
  logic [1:0]  grant;

  // arbiter side
  modport slave (
    input  c_req, c_wen, c_addr, c_wdata,
    input  u_req, u_wen, u_addr, u_wdata,
    input  m_rdata, io_rdata,
    output c_rdata, c_ack, u_rdata, u_ack,
    output mRead, mWrite, ioRead, ioWrite,
    output addr_out, wdata_out, grant
  );

  // requester / memory environment side
  modport master (
    output c_req, c_wen, c_addr, c_wdata,
    output u_req, u_wen, u_addr, u_wdata,
    output m_rdata, io_rdata,
    input  c_rdata, c_ack, u_rdata, u_ack,
    input  mRead, mWrite, ioRead, ioWrite,
    input  addr_out, wdata_out, grant
  );
endinterface

// File: rtl/dmem_io_arbiter.sv
// Round-robin arbiter sharing one data-memory/IO port between the CPU and
// the UART loader. One transaction in flight; IO vs memory decoded from the
// latched address page. Strobes are only active in the single ACCESS cycle.
module dmem_io_arbiter #(
  parameter int          MEM_LATENCY = 1,
  parameter logic [21:0] IO_PAGE     = 22'h3FFFFF
) (
  input logic               clk,
  input logic               rst,
  dmem_io_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  req_t        txn_q;
  req_t        win_req;
  logic        last_u_q;
  logic [1:0]  grant_q;
  logic [31:0] c_rdata_q, u_rdata_q;

  logic        any_req, pick_u, is_io, is_rd;
  logic        cap_en;
  logic [31:0] cap_data;
  logic        m_rd, io_rd, io_wr;
  logic [3:0]  m_wr;

  // Tie goes to whoever was not granted last.
  assign any_req = bus.c_req | bus.u_req;
  assign pick_u  = bus.u_req & (~bus.c_req | ~last_u_q);
  assign win_req = pick_u ? '{bus.u_wen, bus.u_addr, bus.u_wdata}
                          : '{bus.c_wen, bus.c_addr, bus.c_wdata};
  assign is_io   = (txn_q.addr[31:10] == IO_PAGE);
  assign is_rd   = (txn_q.wen == 4'b0000);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, access strobes and read-data capture selection.
  always_comb begin
    state_d  = state_q;
    m_rd     = 1'b0;
    m_wr     = 4'b0000;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    cap_en   = 1'b0;
    cap_data = '0;
    case (state_q)
      IDLE:   if (any_req) state_d = ACCESS;
      ACCESS: begin
        if (is_io) begin
          io_rd = is_rd;
          io_wr = ~is_rd;
        end else begin
          m_rd = is_rd;
          m_wr = txn_q.wen;
        end
        if (is_rd && !is_io) begin
          state_d = WAIT;
        end else begin
          // writes return zero; IO reads are already valid this cycle
          state_d  = RESP;
          cap_en   = 1'b1;
          cap_data = is_rd ? {8'h00, bus.io_rdata} : 32'h0;
        end
      end
      WAIT: begin
        // counter about to hit zero: memory data is valid now
        if (cnt_q == 3'd1) begin
          state_d  = RESP;
          cap_en   = 1'b1;
          cap_data = bus.m_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch, latency counter, grant/pointer and per-requester rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      txn_q     <= '0;
      last_u_q  <= 1'b1;
      grant_q   <= 2'b00;
      c_rdata_q <= '0;
      u_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          txn_q   <= win_req;
          grant_q <= pick_u ? 2'b10 : 2'b01;
        end
        ACCESS: cnt_q <= LAT;
        WAIT:   cnt_q <= cnt_q - 3'd1;
        RESP: begin
          last_u_q <= grant_q[1];
          grant_q  <= 2'b00;
        end
        default: ;
      endcase
      if (cap_en) begin
        if (grant_q[1]) u_rdata_q <= cap_data;
        else            c_rdata_q <= cap_data;
      end
    end
  end

  assign bus.mRead     = m_rd;
  assign bus.mWrite    = m_wr;
  assign bus.ioRead    = io_rd;
  assign bus.ioWrite   = io_wr;
  assign bus.addr_out  = txn_q.addr;
  assign bus.wdata_out = txn_q.wdata;
  assign bus.grant     = grant_q;
  assign bus.c_ack     = (state_q == RESP) & grant_q[0];
  assign bus.u_ack     = (state_q == RESP) & grant_q[1];
  assign bus.c_rdata   = c_rdata_q;
  assign bus.u_rdata   = u_rdata_q;

endmodule
